data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
- Responder side of the CPU data-memory interface.
- Accepts the CPU's memory-stage requests: enable, 4-bit byte write enables, byte address and write data. Returns read data after a configurable number of wait states.
- Drives a stall back to the pipeline until the access completes.
- Sits between the CPU top and the testbench/SoC as the data RAM, and replaces a zero-latency behavioural memory.

Parameters:
- DEPTH_LOG2, 10, log2 of the number of 32-bit words stored (1024 words = 4 KiB window at address 0).
- WAIT_CYCLES, 2, wait states inserted between acceptance and completion; 0 is legal.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- en  input  1  request present (CPU memory enable).
- we  input  4  byte write enables, bit i covers wdata[8i+7:8i]; 4'b0000 = read.
- addr  input  32  byte address; bits [1:0] ignored (word-aligned access).
- wdata  input  32  write data, already lane-aligned by the CPU.
- rdata  output  32  read data, registered.
- valid  output  1  one-cycle pulse: access complete, rdata/err meaningful.
- err  output  1  pulses with valid when the address is outside the window.
- stall  output  1  combinational hold request to the CPU pipeline.

Behaviour:
- FSM states:
  - IDLE: if en=1, capture addr/we/wdata. Go to WAIT if WAIT_CYCLES>0, else DONE.
  - WAIT: load wcnt=WAIT_CYCLES-1 on entry. Decrement each cycle. At wcnt==0, commit the access and go to DONE.
  - DONE: valid=1 for exactly one cycle. Return to IDLE unconditionally. en is ignored in DONE, because it is the same request now being released.
- stall = (state==IDLE && en) || state==WAIT. stall is 0 in DONE, and 0 while rst=0.
- Latency:
  - Request seen in IDLE at cycle 0; valid at cycle WAIT_CYCLES+1.
  - stall is high for cycles 0..WAIT_CYCLES.
  - Next request is accepted at the earliest at cycle WAIT_CYCLES+2.
- Commit happens on the clock edge entering DONE.
  - Word index = captured addr[DEPTH_LOG2+1:2].
  - Read-first: rdata <= the old word at the index, for reads and writes alike.
  - Only lanes with we[i]=1 are updated; other lanes keep their value.
  - we=4'b1111 is a full-word store; 4'b0000 writes nothing.
- Out-of-range: captured addr[31:DEPTH_LOG2+2] != 0.
  - No array write; rdata <= 0.
  - err=1 together with valid. Latency is unchanged.
- Reset (rst=0, asynchronous):
  - state=IDLE, wcnt=0, rdata=0, valid=0, err=0, stall=0.
  - Memory contents are not reset; they keep their prior value (X after power-up).
- Reset mid-operation (WAIT): request aborted, no write committed, no valid pulse.
- Reset asserted on the DONE edge: the commit already taken stands.
- Address and data changes on the inputs after acceptance have no effect; the captured values are used.
- Counter width is $clog2(WAIT_CYCLES+1), minimum 1 bit.

Decomposition:
- Package data_mem_pkg:
  - state enum {IDLE, WAIT, DONE}, 2 bits.
  - localparams WORD_W=32 and BYTES=4.
  - A function that checks the address-window bound.
- One sub-module, mem_bank_be: a synchronous single-port, read-first RAM of 2^DEPTH_LOG2 x 32.
  - Per-byte write enables.
  - Ports: clk, ce, we[3:0], idx, wdata, rdata.
- The FSM, counter, capture registers and stall logic stay in data_mem_responder.

Test Plan:
- Full-word store: WAIT_CYCLES=2; en=1, we=4'hF, addr=0x10, wdata=0xDEADBEEF.
  - stall high for cycles 0-2; valid at cycle 3 with err=0.
  - A follow-up read of 0x10 returns 0xDEADBEEF on its valid.
- Byte store: word 0x10 = 0xDEADBEEF; store we=4'b0010, wdata=0x00005A00.
  - The read then returns 0xDEAD5AEF.
  - The store's own valid cycle shows rdata=0xDEADBEEF (read-first).
- Zero wait states: WAIT_CYCLES=0; back-to-back reads of 0x0 and 0x4 (with en held) follow the schedule below.

  | Cycle | stall | valid | Request in progress |
  |-------|-------|-------|---------------------|
  | 0 | 1 | 0 | read 0x0 accepted |
  | 1 | 0 | 1 | read 0x0 completes |
  | 2 | 1 | 0 | read 0x4 accepted |
  | 3 | 0 | 1 | read 0x4 completes |

  - No request is lost or duplicated.
- Out-of-range write: DEPTH_LOG2=10; write to addr=0x00001000.
  - valid and err both pulse at the normal latency; rdata=0.
  - A read of 0x0 is unchanged.
- Reset mid-WAIT: WAIT_CYCLES=3; write 0x11223344 to 0x20, then drive rst=0 at cycle 2.
  - Outputs go to 0 immediately (asynchronously); no valid pulse.
  - After release, reading 0x20 returns its prior contents.
- Address change after acceptance: change addr/wdata during WAIT.
  - The access uses the values captured at cycle 0.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// in_window() decides whether a byte address falls inside the RAM window at address 0.
package data_mem_pkg;

  localparam int WORD_W = 32;
  localparam int BYTES  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic in_window(input logic [WORD_W-1:0] addr, input int depth_log2);
    return (addr >> (depth_log2 + 2)) == '0;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// CPU data-memory bus: request (en/we/addr/wdata) from the CPU, response (rdata/valid/err)
// and the stall hold request back to it.
interface data_mem_responder_if;
  import data_mem_pkg::*;

  logic              en;
  logic [BYTES-1:0]  we;
  logic [WORD_W-1:0] addr;
  logic [WORD_W-1:0] wdata;
  logic [WORD_W-1:0] rdata;
  logic              valid;
  logic              err;
  logic              stall;

  modport master (output en, we, addr, wdata, input rdata, valid, err, stall);
  modport slave  (input en, we, addr, wdata, output rdata, valid, err, stall);

endinterface

// File: rtl/data_mem_responder_bank.sv
// Single-port read-first RAM, 2^DEPTH_LOG2 x 32, per-byte write enables; rdata one cycle after ce.
// No backpressure: every ce cycle performs the access. Contents and rdata are not reset.
module mem_bank_be
  import data_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  ce,
  input  logic [BYTES-1:0]      we,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     rdata
);

  logic [WORD_W-1:0] mem_q [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (ce) begin
      rdata <= mem_q[idx];
      for (int i = 0; i < BYTES; i++) begin
        if (we[i]) begin
          mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data RAM responder: request accepted in IDLE, valid/rdata/err WAIT_CYCLES+1 cycles later.
// Holds the CPU with a combinational stall from acceptance until the completing cycle.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus
);

  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] WLOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [BYTES-1:0]  we_q, we_d;
  logic              rd_sel_q, rd_sel_d;
  logic              commit;

  logic [WORD_W-1:0] acc_addr;
  logic [WORD_W-1:0] acc_wdata;
  logic [BYTES-1:0]  acc_we;
  logic              acc_in_win;
  logic              bank_ce;
  logic [WORD_W-1:0] bank_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      wcnt_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= '0;
      rd_sel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      rd_sel_q <= rd_sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.en) begin
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          we_d    = bus.we;
          if (WAIT_CYCLES == 0) begin
            state_d = DONE;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            wcnt_d  = WLOAD;
          end
        end
      end
      WAIT: begin
        if (wcnt_q == '0) begin
          state_d = DONE;
          commit  = 1'b1;
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With zero wait states the commit shares the acceptance edge, so the live inputs are used.
  always_comb begin
    acc_addr   = (state_q == IDLE) ? bus.addr  : addr_q;
    acc_wdata  = (state_q == IDLE) ? bus.wdata : wdata_q;
    acc_we     = (state_q == IDLE) ? bus.we    : we_q;
    acc_in_win = in_window(acc_addr, DEPTH_LOG2);
    bank_ce    = commit && acc_in_win;
    rd_sel_d   = commit ? acc_in_win : rd_sel_q;
    bus.stall  = rst && (((state_q == IDLE) && bus.en) || (state_q == WAIT));
    bus.valid  = (state_q == DONE);
    bus.err    = (state_q == DONE) && !rd_sel_q;
    bus.rdata  = rd_sel_q ? bank_rdata : '0;
  end

  mem_bank_be #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_bank (
    .clk   (clk),
    .ce    (bank_ce),
    .we    (acc_we),
    .idx   (acc_addr[DEPTH_LOG2+1:2]),
    .wdata (acc_wdata),
    .rdata (bank_rdata)
  );

endmodule
